fft_twiddle_gen: RTL
====================

Name: fft_twiddle_gen

Overview:
Parametrised twiddle-factor generator for one stage of the radix-2 DIF single-path delay-feedback (SDF) pipeline FFT. It replaces the per-stage hand-written twiddle tables.
- Counts the samples of a frame internally and derives the twiddle exponent for the configured stage.
- Reads a shared quarter-wave cosine ROM and rebuilds cos/sin through symmetry.
- Supports forward and inverse transforms; the mode is selected per frame.
- Feeds the stage's complex multiplier, time-aligned with the butterfly output through a fixed 2-cycle latency.

Parameters:
- N, 256: FFT length, power of two, N >= 8.
- SIZE, 8: log2(N).
- STAGE, 2: stage index, 1..SIZE. Values outside this range are an elaboration error.
- bit_width_tw, 14: signed width of each twiddle component. Unity = 2^(bit_width_tw-2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame sync. Qualified by in_valid, it marks sample 0 of a frame.
- in_valid  in  1  one butterfly-output sample present this cycle.
- inv  in  1  1 = inverse FFT (conjugate twiddles). Sampled only at the frame's first sample.
- cos_data  out  bit_width_tw  signed real part of W.
- sin_data  out  bit_width_tw  signed imaginary part of W.
- tw_idx  out  SIZE-1  exponent e matching the current outputs.
- out_valid  out  1  cos_data/sin_data/tw_idx valid.
- frame_done  out  1  one-cycle pulse, aligned with out_valid, on the last sample (N-1) of a frame.

Behaviour:
- Definitions:
  - L = N >> (STAGE-1).
  - cnt = SIZE-bit sample counter.
  - p = cnt mod L.
- Exponent:
  - p < L/2: e = 0.
  - p >= L/2: e = (p - L/2) << (STAGE-1).
  - Range is 0..N/2-1.
- Twiddle, with θ = 2πe/N and S = 2^(bit_width_tw-2):
  - cos_data = round(S·cosθ).
  - Forward: sin_data = -round(S·sinθ).
  - Inverse: sin_data = +round(S·sinθ).
- ROM:
  - Entries C[i] = round(S·cos(2πi/N)), i = 0..N/4 (N/4+1 entries).
  - Filled at elaboration by an initial/function loop; no external file.
  - Round half away from zero.
- Symmetry:
  - e <= N/4: cos = C[e], sin = C[N/4-e].
  - e > N/4: cos = -C[N/2-e], sin = C[e-N/4].
  - Negation is exact: |C| <= S, so no overflow.
- Counter and inverse-mode latch:
  - Counter advances only on in_valid.
  - in_valid & start: cnt used for this sample = 0, next cnt = 1, inv latched into inv_q.
  - in_valid & !start: uses cnt, then cnt = cnt + 1, wrapping N-1 -> 0.
  - On the wrap, inv is re-latched, so back-to-back frames need no start.
  - start without in_valid is ignored.
  - start in mid-frame aborts the frame: the counter restarts at 0. No frame_done is issued for the aborted frame.
- Pipeline, total latency 2 cycles from in_valid to out_valid:
  - P1 registers e, the ROM addresses, the cos/sin negate flags, the effective inv and valid.
  - P2 registers the ROM read, the sign application, tw_idx, out_valid and frame_done.
  - Bubbles in in_valid propagate as out_valid = 0. Data outputs hold their last value while out_valid = 0.
- Reset:
  - cnt = 0, inv_q = 0, all pipeline valids = 0.
  - cos_data = 0, sin_data = 0, tw_idx = 0, out_valid = 0, frame_done = 0.
  - Reset asserted mid-frame drops in-flight samples. The next frame requires start, or begins at cnt = 0 implicitly.
- Effective inv for a sample: inv when that sample is the frame's first (start or wrap), else inv_q.

Test Plan:
- N=16, SIZE=4, STAGE=1, forward; start with 16 consecutive in_valid -> out_valid 2 cycles later. Samples 0..7 give (4096,0), e=0. Samples 8..15 give e=0..7; e=2 -> (2896,-2896); e=4 -> (0,-4096); e=6 -> (-2896,-2896). frame_done on sample 15 only.
- N=16, STAGE=2, forward -> per 8-sample block, e = 0,0,0,0,0,2,4,6. Sample 7 gives (-2896,-2896). Pattern repeats for samples 8..15.
- Inverse mode: inv=1 at start, then inv toggles mid-frame -> the whole frame has sin_data sign-flipped vs forward (e=4 -> (0,+4096)). The next frame, with inv=0 at the wrap, reverts to forward.
- Bubbles: in_valid pattern 1,0,0,1,1 -> out_valid replicates it 2 cycles later. The counter advances only on valid cycles; data outputs hold during gaps.
- Mid-frame start at cnt=11 -> that sample is treated as cnt=0 (e=0, (4096,0)). No frame_done for the aborted frame. frame_done appears 15 valid samples later.
- Async rst asserted mid-frame, between clock edges -> all outputs 0 immediately. After release, the first valid sample without start uses cnt=0. Last stage STAGE=SIZE always gives e=0 -> (4096,0).

Source files
------------

// File: rtl/fft_twiddle_gen.sv
`timescale 1ns/1ps
// Twiddle-factor source for one stage of a radix-2 DIF SDF pipeline FFT.
// Quarter-wave cosine ROM plus symmetry; 2-cycle latency matches the butterfly output.
module fft_twiddle_gen #(
  parameter int N            = 256,
  parameter int SIZE         = 8,
  parameter int STAGE        = 2,
  parameter int bit_width_tw = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic                    inv,
  output logic [bit_width_tw-1:0] cos_data,
  output logic [bit_width_tw-1:0] sin_data,
  output logic [SIZE-2:0]         tw_idx,
  output logic                    out_valid,
  output logic                    frame_done
);

  localparam int W     = bit_width_tw;
  localparam int AW    = SIZE - 1;
  localparam int Q     = N / 4;
  localparam int ROM_N = Q + 1;
  localparam int L     = N >> (STAGE - 1);

  localparam logic [SIZE-1:0] L_MASK = SIZE'(L - 1);
  localparam logic [SIZE-1:0] HALF_L = SIZE'(L / 2);
  localparam logic [SIZE-1:0] LAST   = SIZE'(N - 1);
  localparam logic [AW-1:0]   QA     = AW'(Q);
  // N/2 does not fit in AW bits; it wraps to 0, which still yields N/2-e modulo 2^AW.
  localparam logic [AW-1:0]   HALF_N = AW'(N / 2);

  if (STAGE < 1 || STAGE > SIZE || N != (1 << SIZE) || N < 8) begin : g_badParams
    $error("fft_twiddle_gen: illegal N/SIZE/STAGE combination");
  end

  function automatic logic [ROM_N*W-1:0] buildRom();
    logic [ROM_N*W-1:0] v;
    real x;
    int  k;
    v = '0;
    for (int i = 0; i < ROM_N; i++) begin
      x = (2.0 ** (W - 2)) * $cos(2.0 * 3.14159265358979323846 * i / N);
      k = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
      v[i*W +: W] = W'(k);
    end
    return v;
  endfunction

  localparam logic [ROM_N*W-1:0] ROM_FLAT = buildRom();

  logic [W-1:0] w_rom [ROM_N];
  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    assign w_rom[g] = ROM_FLAT[g*W +: W];
  end

  logic [SIZE-1:0] r_cnt;
  logic            r_invQ;
  logic [SIZE-1:0] w_cntUse;
  logic [SIZE-1:0] w_p;
  logic            w_first;
  logic            w_effInv;
  logic [AW-1:0]   w_e;
  logic [AW-1:0]   w_cosAddr;
  logic [AW-1:0]   w_sinAddr;
  logic            w_cosNeg;

  logic            r_valid1;
  logic            r_last1;
  logic            r_cosNeg1;
  logic            r_sinNeg1;
  logic [AW-1:0]   r_e1;
  logic [AW-1:0]   r_cosAddr1;
  logic [AW-1:0]   r_sinAddr1;
  logic [W-1:0]    w_cosRom;
  logic [W-1:0]    w_sinRom;

  // A sample is a frame's first either through start or by the counter sitting at 0.
  always_comb begin
    w_cntUse  = start ? '0 : r_cnt;
    w_first   = (w_cntUse == '0);
    w_effInv  = w_first ? inv : r_invQ;
    w_p       = w_cntUse & L_MASK;
    w_e       = '0;
    if (w_p >= HALF_L) begin
      w_e = AW'((w_p - HALF_L) << (STAGE - 1));
    end
    w_cosNeg  = 1'b0;
    w_cosAddr = w_e;
    w_sinAddr = QA - w_e;
    if (w_e > QA) begin
      w_cosNeg  = 1'b1;
      w_cosAddr = HALF_N - w_e;
      w_sinAddr = w_e - QA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_invQ <= 1'b0;
    end else if (in_valid) begin
      r_cnt <= w_cntUse + 1'b1;
      if (w_first) begin
        r_invQ <= inv;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid1   <= 1'b0;
      r_last1    <= 1'b0;
      r_cosNeg1  <= 1'b0;
      r_sinNeg1  <= 1'b0;
      r_e1       <= '0;
      r_cosAddr1 <= '0;
      r_sinAddr1 <= '0;
    end else begin
      r_valid1 <= in_valid;
      if (in_valid) begin
        r_last1    <= (w_cntUse == LAST);
        r_cosNeg1  <= w_cosNeg;
        r_sinNeg1  <= ~w_effInv;
        r_e1       <= w_e;
        r_cosAddr1 <= w_cosAddr;
        r_sinAddr1 <= w_sinAddr;
      end
    end
  end

  assign w_cosRom = w_rom[r_cosAddr1];
  assign w_sinRom = w_rom[r_sinAddr1];

  // Data outputs only move on valid samples so they hold through bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cos_data   <= '0;
      sin_data   <= '0;
      tw_idx     <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= r_valid1;
      frame_done <= r_valid1 & r_last1;
      if (r_valid1) begin
        tw_idx   <= r_e1;
        cos_data <= r_cosNeg1 ? -w_cosRom : w_cosRom;
        sin_data <= r_sinNeg1 ? -w_sinRom : w_sinRom;
      end
    end
  end

endmodule
